// File: rtl/button_gesture_decoder.sv
// Button gesture decoder: turns debounced press/release events into
// single-click, double-click, long-press, auto-repeat pulses and a hold level.
// A single shared timer measures press, gap and repeat intervals. It restarts
// on every state change and idles at zero in IDLE, so it never wraps.
module button_gesture_decoder #(
    parameter int LONG_CYCLES   = 25000000,
    parameter int GAP_CYCLES    = 5000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic arst_n,
    input  logic sw_state_i,
    input  logic sw_down_i,
    input  logic sw_up_i,
    output logic click_o,
    output logic dbl_click_o,
    output logic long_o,
    output logic repeat_o,
    output logic hold_o
);

    localparam int MAX_LG     = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int MAX_CYCLES = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES) + 1;

    localparam logic [TIMER_W-1:0] LONG_TC   = TIMER_W'(LONG_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_TC    = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] REPEAT_TC = TIMER_W'(REPEAT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [TIMER_W-1:0]   timer_reg;
    logic [TIMER_W-1:0]   timer_next;
    logic                 repeat_clear;

    logic                 release_evt;
    logic                 press_evt;

    logic                 click_next;
    logic                 dbl_click_next;
    logic                 long_next;
    logic                 repeat_next;
    logic                 hold_next;

    // A simultaneous down/up pair is a glitch, not a press; a dropped level
    // counts as a release even if the up pulse was missed.
    assign release_evt = sw_up_i | ~sw_state_i;
    assign press_evt   = sw_down_i & ~sw_up_i;

    // State and timer registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg <= ST_IDLE;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
        end
    end

    // Next-state decision; release beats timer expiry, press beats gap timeout
    always_comb begin
        state_next   = state_reg;
        repeat_clear = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (press_evt) state_next = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (release_evt)              state_next = ST_WAIT2;
                else if (timer_reg == LONG_TC) state_next = ST_LONG;
            end
            ST_WAIT2: begin
                if (press_evt)                state_next = ST_PRESS2;
                else if (timer_reg == GAP_TC) state_next = ST_IDLE;
            end
            ST_PRESS2: begin
                if (release_evt)              state_next = ST_IDLE;
                else if (timer_reg == LONG_TC) state_next = ST_LONG;
            end
            ST_LONG: begin
                if (release_evt)                 state_next = ST_IDLE;
                else if (timer_reg == REPEAT_TC) repeat_clear = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Timer restarts on state entry and on each repeat; parked at zero in IDLE
    always_comb begin
        if ((state_next != state_reg) || repeat_clear || (state_reg == ST_IDLE)) begin
            timer_next = '0;
        end else begin
            timer_next = timer_reg + TIMER_W'(1);
        end
    end

    // Output decode from the current state and sampled events
    always_comb begin
        click_next     = (state_reg == ST_WAIT2) && !press_evt && (timer_reg == GAP_TC);
        dbl_click_next = (state_reg == ST_PRESS2) && release_evt;
        long_next      = ((state_reg == ST_PRESS1) || (state_reg == ST_PRESS2))
                         && !release_evt && (timer_reg == LONG_TC);
        repeat_next    = (state_reg == ST_LONG) && !release_evt && (timer_reg == REPEAT_TC);
        hold_next      = (state_next == ST_LONG);
    end

    // Registered outputs so every pulse is a clean one-cycle strobe
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            click_o     <= 1'b0;
            dbl_click_o <= 1'b0;
            long_o      <= 1'b0;
            repeat_o    <= 1'b0;
            hold_o      <= 1'b0;
        end else begin
            click_o     <= click_next;
            dbl_click_o <= dbl_click_next;
            long_o      <= long_next;
            repeat_o    <= repeat_next;
            hold_o      <= hold_next;
        end
    end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Self-checking bench for button_gesture_decoder with short timing parameters.
// Expected outputs come from a timestamp-based gesture model: events are
// recorded by edge number and pulses are predicted from elapsed edge counts.
module tb_button_gesture_decoder;

    localparam int LONG_C   = 8;
    localparam int GAP_C    = 4;
    localparam int REPEAT_C = 3;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic sw_state_i = 1'b0;
    logic sw_down_i = 1'b0;
    logic sw_up_i = 1'b0;
    logic click_o, dbl_click_o, long_o, repeat_o, hold_o;

    button_gesture_decoder #(
        .LONG_CYCLES  (LONG_C),
        .GAP_CYCLES   (GAP_C),
        .REPEAT_CYCLES(REPEAT_C)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .sw_state_i (sw_state_i),
        .sw_down_i  (sw_down_i),
        .sw_up_i    (sw_up_i),
        .click_o    (click_o),
        .dbl_click_o(dbl_click_o),
        .long_o     (long_o),
        .repeat_o   (repeat_o),
        .hold_o     (hold_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Gesture model: timestamps of the last press, release and long event
    bit m_active  = 1'b0;
    bit m_pressed = 1'b0;
    bit m_long    = 1'b0;
    int m_clicks  = 0;
    int t_press   = 0;
    int t_rel     = 0;
    int t_long    = 0;
    int edge_n    = 0;

    // Observed pulse statistics, cleared per directed transaction
    int cnt_click, cnt_dbl, cnt_long, cnt_rep;
    int e_click_at, e_dbl_at, e_long_at, e_rep_at, hold_fall_at;

    task automatic clear_counts();
        cnt_click = 0; cnt_dbl = 0; cnt_long = 0; cnt_rep = 0;
        e_click_at = -1; e_dbl_at = -1; e_long_at = -1; e_rep_at = -1;
        hold_fall_at = -1;
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        n_checks++;
        assert (got === want)
        else begin
            n_fail++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // One clock: drive inputs at the falling edge, predict at the rising edge,
    // compare at the next falling edge.
    task automatic step(input logic st, input logic dn, input logic up, input string tag);
        bit rel, prs;
        bit x_click, x_dbl, x_long, x_rep, x_hold;
        bit prev_hold;
        int n;
        sw_state_i = st;
        sw_down_i  = dn;
        sw_up_i    = up;
        @(posedge clk);
        n = edge_n;
        edge_n++;
        rel = up | ~st;
        prs = dn & ~up;
        x_click = 0; x_dbl = 0; x_long = 0; x_rep = 0;
        prev_hold = m_long;
        if (!arst_n) begin
            m_active = 0; m_pressed = 0; m_long = 0; m_clicks = 0;
        end else if (m_long) begin
            if (rel) begin
                m_long = 0; m_active = 0; m_pressed = 0;
            end else if ((n - t_long) % REPEAT_C == 0) begin
                x_rep = 1;
            end
        end else if (m_active && m_pressed) begin
            if (rel) begin
                if (m_clicks == 1) begin
                    m_pressed = 0; t_rel = n;
                end else begin
                    x_dbl = 1; m_active = 0; m_pressed = 0;
                end
            end else if (n - t_press == LONG_C) begin
                x_long = 1; m_long = 1; t_long = n;
            end
        end else if (m_active) begin
            if (prs) begin
                m_pressed = 1; m_clicks = 2; t_press = n;
            end else if (n - t_rel == GAP_C) begin
                x_click = 1; m_active = 0;
            end
        end else if (prs) begin
            m_active = 1; m_pressed = 1; m_clicks = 1; t_press = n;
        end
        x_hold = m_long;
        @(negedge clk);
        n_checks++;
        assert ({click_o, dbl_click_o, long_o, repeat_o, hold_o} ===
                {x_click, x_dbl, x_long, x_rep, x_hold})
        else begin
            n_fail++;
            $error("FAIL %s edge=%0d got(clk,dbl,long,rep,hold)=%b want=%b", tag, n,
                   {click_o, dbl_click_o, long_o, repeat_o, hold_o},
                   {x_click, x_dbl, x_long, x_rep, x_hold});
        end
        if (click_o === 1'b1)     begin cnt_click++; e_click_at = n; end
        if (dbl_click_o === 1'b1) begin cnt_dbl++;   e_dbl_at   = n; end
        if (long_o === 1'b1)      begin cnt_long++;  e_long_at  = n; end
        if (repeat_o === 1'b1)    begin cnt_rep++;   e_rep_at   = n; end
        if (prev_hold && hold_o === 1'b0) hold_fall_at = n;
    endtask

    task automatic press(input string tag);   step(1'b1, 1'b1, 1'b0, tag); endtask
    task automatic hold(input string tag);    step(1'b1, 1'b0, 1'b0, tag); endtask
    task automatic release_b(input string tag); step(1'b0, 1'b0, 1'b1, tag); endtask
    task automatic idle(input string tag);    step(1'b0, 1'b0, 1'b0, tag); endtask

    initial begin
        int base;
        int kind, hlen, glen;

        clear_counts();
        // Reset state
        repeat (3) idle("reset");
        check_int("reset_outputs", int'({click_o, dbl_click_o, long_o, repeat_o, hold_o}), 0);
        arst_n = 1'b1;
        repeat (2) idle("post_reset");

        // Single click: press e0, release e3
        clear_counts(); base = edge_n;
        press("click"); hold("click"); hold("click"); release_b("click");
        repeat (6) idle("click");
        check_int("click_count", cnt_click, 1);
        check_int("click_edge", e_click_at - base, 7);
        check_int("click_others", cnt_dbl + cnt_long + cnt_rep, 0);
        $display("txn single_click edge=%0d clicks=%0d", base, cnt_click);

        // Double click: press e0, release e2, press e4, release e6
        clear_counts(); base = edge_n;
        press("dbl"); hold("dbl"); release_b("dbl"); idle("dbl");
        press("dbl"); hold("dbl"); release_b("dbl");
        repeat (6) idle("dbl");
        check_int("dbl_count", cnt_dbl, 1);
        check_int("dbl_edge", e_dbl_at - base, 6);
        check_int("dbl_no_click", cnt_click, 0);
        $display("txn double_click edge=%0d dbls=%0d", base, cnt_dbl);

        // Long press with auto-repeat: held through e20, released at e21
        clear_counts(); base = edge_n;
        press("long");
        repeat (20) hold("long");
        release_b("long");
        repeat (3) idle("long");
        check_int("long_count", cnt_long, 1);
        check_int("long_edge", e_long_at - base, 8);
        check_int("repeat_count", cnt_rep, 4);
        check_int("repeat_last_edge", e_rep_at - base, 20);
        check_int("hold_fall_edge", hold_fall_at - base, 21);
        $display("txn long_press edge=%0d repeats=%0d", base, cnt_rep);

        // Release on PRESS1 terminal count, press on WAIT2 timeout
        clear_counts(); base = edge_n;
        press("prio");
        repeat (7) hold("prio");
        release_b("prio");
        repeat (3) idle("prio");
        press("prio"); hold("prio"); release_b("prio");
        repeat (6) idle("prio");
        check_int("prio_no_long", cnt_long, 0);
        check_int("prio_no_click", cnt_click, 0);
        check_int("prio_dbl_edge", e_dbl_at - base, 14);
        $display("txn priority edge=%0d dbls=%0d", base, cnt_dbl);

        // Level drop without sw_up_i acts as release
        clear_counts(); base = edge_n;
        press("drop"); hold("drop"); idle("drop");
        repeat (6) idle("drop");
        check_int("drop_click_edge", e_click_at - base, 6);
        $display("txn level_drop edge=%0d clicks=%0d", base, cnt_click);

        // Coincident down/up in IDLE is not a press
        clear_counts(); base = edge_n;
        step(1'b0, 1'b1, 1'b1, "glitch");
        repeat (12) idle("glitch");
        check_int("glitch_no_pulse", cnt_click + cnt_dbl + cnt_long + cnt_rep, 0);
        $display("txn down_up_glitch edge=%0d pulses=%0d", base,
                 cnt_click + cnt_dbl + cnt_long + cnt_rep);

        // Asynchronous reset in LONG clears outputs immediately
        clear_counts(); base = edge_n;
        press("arst");
        repeat (9) hold("arst");
        check_int("arst_hold_before", int'(hold_o), 1);
        arst_n = 1'b0;
        #1;
        check_int("arst_immediate", int'({click_o, dbl_click_o, long_o, repeat_o, hold_o}), 0);
        release_b("arst");
        idle("arst");
        arst_n = 1'b1;
        clear_counts();
        repeat (4) idle("arst_after");
        repeat (12) step(1'b1, 1'b0, 1'b0, "arst_level_only");
        idle("arst_after");
        check_int("arst_no_pulses", cnt_click + cnt_dbl + cnt_long + cnt_rep + int'(hold_o), 0);
        press("arst_fresh"); release_b("arst_fresh");
        repeat (6) idle("arst_fresh");
        check_int("arst_fresh_click", cnt_click, 1);
        $display("txn async_reset edge=%0d clicks_after=%0d", base, cnt_click);

        // Randomized gestures against the model
        for (int g = 0; g < 80; g++) begin
            clear_counts(); base = edge_n;
            kind = $urandom_range(0, 9);
            hlen = $urandom_range(1, 14);
            glen = $urandom_range(0, 7);
            if (kind == 0) begin
                step(1'b0, 1'b1, 1'b1, "rnd_glitch");
            end else begin
                press("rnd");
                for (int h = 1; h < hlen; h++) hold("rnd");
                if (kind == 1) idle("rnd_drop");
                else release_b("rnd");
            end
            for (int i = 0; i < glen; i++) idle("rnd");
            $display("txn random g=%0d kind=%0d hold=%0d gap=%0d pulses c%0d d%0d l%0d r%0d",
                     g, kind, hlen, glen, cnt_click, cnt_dbl, cnt_long, cnt_rep);
        end
        repeat (20) idle("drain");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/button_gesture_decoder.md
BUTTON_GESTURE_DECODER -- requirements
Module: button_gesture_decoder

Interface
REQ-001 Parameter LONG_CYCLES, default 25000000, press duration in clk cycles that qualifies as a long press (>=2).
REQ-002 Parameter GAP_CYCLES, default 5000000, maximum release-to-press gap for a double click (>=2).
REQ-003 Parameter REPEAT_CYCLES, default 5000000, auto-repeat period while long-held (>=2).
REQ-004 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 Port arst_n, input, 1, asynchronous active-low reset.
REQ-006 Port sw_state_i, input, 1, debounced button level (1 = pushed).
REQ-007 Port sw_down_i, input, 1, one-cycle press pulse from debouncer.
REQ-008 Port sw_up_i, input, 1, one-cycle release pulse from debouncer.
REQ-009 Port click_o, output, 1, one-cycle pulse: single click recognised.
REQ-010 Port dbl_click_o, output, 1, one-cycle pulse: double click recognised.
REQ-011 Port long_o, output, 1, one-cycle pulse: long press recognised.
REQ-012 Port repeat_o, output, 1, one-cycle auto-repeat pulse while long-held.
REQ-013 Port hold_o, output, 1, level: high while in LONG state.

Function
REQ-014 FSM states IDLE, PRESS1, WAIT2, PRESS2, LONG; one timer, width $clog2 of the largest parameter plus 1, cleared on every state entry, incremented each cycle otherwise.
REQ-015 release = sw_up_i OR NOT sw_state_i; press = sw_down_i AND NOT sw_up_i; sw_down_i and sw_up_i high together = no press.
REQ-016 IDLE: press -> PRESS1; release ignored.
REQ-017 PRESS1: release -> WAIT2; else timer == LONG_CYCLES-1 -> LONG with long_o; press ignored.
REQ-018 WAIT2: press -> PRESS2; else timer == GAP_CYCLES-1 -> IDLE with click_o; press wins if coincident with timeout.
REQ-019 PRESS2: release -> IDLE with dbl_click_o; else timer == LONG_CYCLES-1 -> LONG with long_o (no dbl_click_o).
REQ-020 LONG: release -> IDLE (hold_o falls, no pulse); else timer == REPEAT_CYCLES-1 -> repeat_o pulse, timer cleared, stay LONG.
REQ-021 Release has priority over timer expiry in PRESS1, PRESS2 and LONG.
REQ-022 All outputs registered; each pulse high exactly one cycle, in the cycle after the edge where its condition was sampled; at most one of click_o/dbl_click_o/long_o/repeat_o high per cycle.
REQ-023 Timing: long_o high LONG_CYCLES edges after the edge sampling the press; click_o GAP_CYCLES edges after the edge sampling the release; repeat_o every REPEAT_CYCLES edges after long_o.
REQ-024 hold_o rises in the same cycle as long_o; falls the cycle after the edge sampling release.
REQ-025 Timer never wraps: each state exits or clears at its terminal count.

Reset
REQ-026 arst_n low: state IDLE, timer 0, all outputs 0 immediately, independent of clk.
REQ-027 Reset asserted mid-gesture discards it; no pulse emitted during reset or on release; decoder waits for a fresh sw_down_i.

Verification (LONG_CYCLES=8, GAP_CYCLES=4, REPEAT_CYCLES=3)
REQ-028 Press at edge 0, release at edge 3, idle -> single click_o pulse after edge 7; no other pulses.
REQ-029 Press e0, release e2, press e4, release e6 -> single dbl_click_o pulse after edge 6; click_o never.
REQ-030 Press at e0, held to e20 -> long_o and hold_o rise after e8; repeat_o after e11, e14, e17, e20; hold_o low after release edge.
REQ-031 Release sampled on same edge as PRESS1 terminal count -> WAIT2, no long_o; press on same edge as WAIT2 timeout -> PRESS2, no click_o.
REQ-032 sw_state_i drops without sw_up_i in PRESS1 -> treated as release; sw_down_i and sw_up_i together in IDLE -> stays IDLE.
REQ-033 arst_n pulsed low during LONG -> hold_o and all outputs 0 immediately; no pulses until next press.
